// File: rtl/memory_island_copy_engine.sv
// Multi-channel block copy/fill engine for the memory island wide ports.
// Round-robin descriptor intake, credit-limited reads, small registered FIFO.
//
// state | meaning
// IDLE  | waiting for a descriptor, arbiter drives desc_ready_o
// RUN   | moving beats (COPY: read->FIFO->write, FILL: pattern->write)
// DONE  | one-cycle completion, pulses done_o / err_o
module memory_island_copy_engine #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 256,
  parameter int NumChannels    = 2,
  parameter int MaxOutstanding = 4,
  parameter int LenWidth       = 24
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                desc_valid_i,
  output logic [NumChannels-1:0]                desc_ready_o,
  input  logic [NumChannels-1:0][AddrWidth-1:0] desc_src_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] desc_dst_i,
  input  logic [NumChannels-1:0][LenWidth-1:0]  desc_len_i,
  input  logic [NumChannels-1:0]                desc_fill_i,
  input  logic [NumChannels-1:0][31:0]          desc_pattern_i,
  output logic [NumChannels-1:0]                done_o,
  output logic [NumChannels-1:0]                err_o,
  output logic                                  busy_o,
  output logic                                  rd_req_o,
  input  logic                                  rd_gnt_i,
  output logic [AddrWidth-1:0]                  rd_addr_o,
  input  logic                                  rd_rvalid_i,
  input  logic [DataWidth-1:0]                  rd_rdata_i,
  output logic                                  wr_req_o,
  input  logic                                  wr_gnt_i,
  output logic [AddrWidth-1:0]                  wr_addr_o,
  output logic [DataWidth-1:0]                  wr_wdata_o,
  output logic [DataWidth/8-1:0]                wr_strb_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntW      = $clog2(MaxOutstanding + 1);
  localparam int ChW       = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int FifoAw    = $clog2(MaxOutstanding);
  localparam int Reps      = DataWidth / 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [AddrWidth-1:0] BeatMask = ~AddrWidth'(StrbWidth - 1);

  logic [1:0]           state;
  logic [ChW-1:0]       rr_ptr;
  logic [ChW-1:0]       grant_idx;
  logic                 grant_any;
  logic [ChW-1:0]       chan;
  logic                 fill_mode;
  logic                 err_flag;
  logic [31:0]          pattern;
  logic [AddrWidth-1:0] src_addr;
  logic [AddrWidth-1:0] dst_addr;
  logic [LenWidth-1:0]  reads_left;
  logic [LenWidth-1:0]  writes_left;
  logic [CntW-1:0]      inflight;
  logic [CntW-1:0]      fifo_count;
  logic [FifoAw-1:0]    fifo_wr_ptr;
  logic [FifoAw-1:0]    fifo_rd_ptr;
  logic [DataWidth-1:0] fifo_mem [MaxOutstanding];

  logic accept;
  logic rd_fire;
  logic wr_fire;
  logic push;
  logic pop;
  logic credit_ok;

  // Two passes: channels at/after the pointer first, then the ones before it.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NumChannels; j++) begin
      if (!grant_any && desc_valid_i[j] && (ChW'(j) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = ChW'(j);
      end
    end
    for (int j = 0; j < NumChannels; j++) begin
      if (!grant_any && desc_valid_i[j] && (ChW'(j) < rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = ChW'(j);
      end
    end
  end

  always_comb begin
    desc_ready_o = '0;
    if (state == ST_IDLE && grant_any) desc_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    done_o = '0;
    err_o  = '0;
    if (state == ST_DONE) begin
      done_o[chan] = 1'b1;
      err_o[chan]  = err_flag;
    end
  end

  assign accept    = (state == ST_IDLE) && grant_any;
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CntW + 1)'(MaxOutstanding);

  assign rd_req_o  = (state == ST_RUN) && !fill_mode && (reads_left != '0) && credit_ok;
  assign wr_req_o  = (state == ST_RUN) && (fill_mode ? (writes_left != '0) : (fifo_count != '0));
  assign rd_fire   = rd_req_o && rd_gnt_i;
  assign wr_fire   = wr_req_o && wr_gnt_i;
  // Responses for reads issued before a reset find inflight at zero and are dropped.
  assign push      = rd_rvalid_i && (inflight != '0);
  assign pop       = wr_fire && !fill_mode;

  assign busy_o     = (state != ST_IDLE);
  assign rd_addr_o  = src_addr;
  assign wr_addr_o  = dst_addr;
  assign wr_strb_o  = {StrbWidth{state == ST_RUN}};
  assign wr_wdata_o = (state != ST_RUN) ? '0 :
                      fill_mode ? {Reps{pattern}} : fifo_mem[fifo_rd_ptr];

  function automatic logic [FifoAw-1:0] ptr_next(input logic [FifoAw-1:0] p);
    return (p == FifoAw'(MaxOutstanding - 1)) ? '0 : p + FifoAw'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      chan        <= '0;
      fill_mode   <= 1'b0;
      err_flag    <= 1'b0;
      pattern     <= '0;
      src_addr    <= '0;
      dst_addr    <= '0;
      reads_left  <= '0;
      writes_left <= '0;
      inflight    <= '0;
      fifo_count  <= '0;
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            chan        <= grant_idx;
            rr_ptr      <= (grant_idx == ChW'(NumChannels - 1)) ? '0 : grant_idx + ChW'(1);
            fill_mode   <= desc_fill_i[grant_idx];
            pattern     <= desc_pattern_i[grant_idx];
            src_addr    <= desc_src_i[grant_idx] & BeatMask;
            dst_addr    <= desc_dst_i[grant_idx] & BeatMask;
            reads_left  <= desc_fill_i[grant_idx] ? '0 : desc_len_i[grant_idx];
            writes_left <= desc_len_i[grant_idx];
            err_flag    <= (desc_len_i[grant_idx] == '0);
            state       <= (desc_len_i[grant_idx] == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_fire && writes_left == LenWidth'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (rd_fire) begin
        src_addr   <= src_addr + AddrWidth'(StrbWidth);
        reads_left <= reads_left - LenWidth'(1);
      end
      if (wr_fire) begin
        dst_addr    <= dst_addr + AddrWidth'(StrbWidth);
        writes_left <= writes_left - LenWidth'(1);
      end

      case ({rd_fire, push})
        2'b10:   inflight <= inflight + CntW'(1);
        2'b01:   inflight <= inflight - CntW'(1);
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CntW'(1);
        2'b01:   fifo_count <= fifo_count - CntW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (push) fifo_wr_ptr <= ptr_next(fifo_wr_ptr);
      if (pop)  fifo_rd_ptr <= ptr_next(fifo_rd_ptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[fifo_wr_ptr] <= rd_rdata_i;
  end

endmodule

// File: tb/tb_memory_island_copy_engine.sv
// Directed bench for memory_island_copy_engine: copy, fill, back-pressure,
// arbitration, zero-length and mid-job reset scenarios.
module tb_memory_island_copy_engine;

  logic              clk;
  logic              rst_i;
  logic [1:0]        desc_valid;
  logic [1:0]        desc_ready;
  logic [1:0][31:0]  desc_src;
  logic [1:0][31:0]  desc_dst;
  logic [1:0][23:0]  desc_len;
  logic [1:0]        desc_fill;
  logic [1:0][31:0]  desc_pattern;
  logic [1:0]        done_o;
  logic [1:0]        err_o;
  logic              busy_o;
  logic              rd_req_o;
  logic              rd_gnt_i;
  logic [31:0]       rd_addr_o;
  logic              rd_rvalid_i;
  logic [255:0]      rd_rdata_i;
  logic              wr_req_o;
  logic              wr_gnt_i;
  logic [31:0]       wr_addr_o;
  logic [255:0]      wr_wdata_o;
  logic [31:0]       wr_strb_o;

  memory_island_copy_engine dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .desc_valid_i   (desc_valid),
    .desc_ready_o   (desc_ready),
    .desc_src_i     (desc_src),
    .desc_dst_i     (desc_dst),
    .desc_len_i     (desc_len),
    .desc_fill_i    (desc_fill),
    .desc_pattern_i (desc_pattern),
    .done_o         (done_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .rd_req_o       (rd_req_o),
    .rd_gnt_i       (rd_gnt_i),
    .rd_addr_o      (rd_addr_o),
    .rd_rvalid_i    (rd_rvalid_i),
    .rd_rdata_i     (rd_rdata_i),
    .wr_req_o       (wr_req_o),
    .wr_gnt_i       (wr_gnt_i),
    .wr_addr_o      (wr_addr_o),
    .wr_wdata_o     (wr_wdata_o),
    .wr_strb_o      (wr_strb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int rv_cnt = 0;

  logic [31:0]  rd_log[$];
  logic [31:0]  wr_addr_log[$];
  logic [255:0] wr_data_log[$];
  logic [31:0]  wr_strb_log[$];
  int           wr_cyc_log[$];
  int           acc_ch[$];
  int           acc_cyc[$];
  int           done_cyc[$];
  logic [1:0]   done_vec[$];
  logic [1:0]   err_vec[$];
  logic [31:0]  pend_addr[$];
  int           pend_due[$];

  function automatic logic [255:0] mkdata(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  // Memory model and bus monitor; responses are kept across reset on purpose.
  always @(posedge clk) begin
    if (!rst_i) begin
      if (rd_req_o && rd_gnt_i) begin
        rd_log.push_back(rd_addr_o);
        pend_addr.push_back(rd_addr_o);
        pend_due.push_back(cyc + lat);
      end
      if (wr_req_o && wr_gnt_i) begin
        wr_addr_log.push_back(wr_addr_o);
        wr_data_log.push_back(wr_wdata_o);
        wr_strb_log.push_back(wr_strb_o);
        wr_cyc_log.push_back(cyc);
      end
      for (int j = 0; j < 2; j++) begin
        if (desc_valid[j] && desc_ready[j]) begin
          acc_ch.push_back(j);
          acc_cyc.push_back(cyc);
        end
      end
      if (done_o != 2'b00) begin
        done_cyc.push_back(cyc);
        done_vec.push_back(done_o);
        err_vec.push_back(err_o);
      end
    end
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rd_rvalid_i = 1'b1;
      rd_rdata_i  = mkdata(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      rv_cnt++;
    end else begin
      rd_rvalid_i = 1'b0;
      rd_rdata_i  = '0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int ch, input logic [31:0] src, input logic [31:0] dst,
                           input logic [23:0] len, input logic fill, input logic [31:0] pat);
    desc_src[ch]     = src;
    desc_dst[ch]     = dst;
    desc_len[ch]     = len;
    desc_fill[ch]    = fill;
    desc_pattern[ch] = pat;
    desc_valid[ch]   = 1'b1;
    #1;
    chk("ready_onehot", desc_ready, 2'b01 << ch);
    @(negedge clk);
    desc_valid = 2'b00;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cyc.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cyc.size() >= target, 1'b1);
  endtask

  int rb, wb, db, ab, rvb;
  logic [255:0] fillpat;

  initial begin
    rst_i = 1'b1;
    desc_valid = '0; desc_src = '0; desc_dst = '0; desc_len = '0;
    desc_fill = '0; desc_pattern = '0;
    rd_gnt_i = 1'b0; wr_gnt_i = 1'b0;
    rd_rvalid_i = 1'b0; rd_rdata_i = '0;
    repeat (3) @(negedge clk);

    chk("rst_rd_req", rd_req_o, 1'b0);
    chk("rst_wr_req", wr_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 2'b00);
    chk("rst_err", err_o, 2'b00);
    chk("rst_wr_addr", wr_addr_o, 32'h0);
    chk("rst_wdata", wr_wdata_o, 256'h0);
    chk("rst_strb", wr_strb_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", desc_ready, 2'b00);

    // COPY ch0 0x1000 -> 0x2000, 4 beats, latency 1
    rd_gnt_i = 1'b1; wr_gnt_i = 1'b1; lat = 1;
    rb = rd_log.size(); wb = wr_addr_log.size(); db = done_cyc.size();
    start_job(0, 32'h1000, 32'h2000, 24'd4, 1'b0, 32'h0);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_rd_req", rd_req_o, 1'b1);
    chk("t1_rd_addr", rd_addr_o, 32'h1000);
    wait_done(db + 1, 60, "t1_timeout");
    chk("t1_busy_clr", busy_o, 1'b0);
    chk("t1_nrd", rd_log.size() - rb, 4);
    chk("t1_nwr", wr_addr_log.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_addr_i", rd_log[rb+i], 32'h1000 + 32'(i * 32));
      chk("t1_wr_addr_i", wr_addr_log[wb+i], 32'h2000 + 32'(i * 32));
      chk("t1_wr_data_i", wr_data_log[wb+i], mkdata(32'h1000 + 32'(i * 32)));
    end
    chk("t1_done_lat", done_cyc[db] - wr_cyc_log[wb+3], 1);
    chk("t1_done_vec", done_vec[db], 2'b01);
    chk("t1_err_vec", err_vec[db], 2'b00);

    // FILL ch1 misaligned dst 0x3010, 3 beats
    fillpat = {8{32'hA5A5_0001}};
    rb = rd_log.size(); wb = wr_addr_log.size(); db = done_cyc.size();
    start_job(1, 32'h0, 32'h3010, 24'd3, 1'b1, 32'hA5A5_0001);
    chk("t2_wr_req", wr_req_o, 1'b1);
    chk("t2_wr_addr", wr_addr_o, 32'h3000);
    chk("t2_rd_req", rd_req_o, 1'b0);
    wait_done(db + 1, 40, "t2_timeout");
    chk("t2_nwr", wr_addr_log.size() - wb, 3);
    chk("t2_nrd", rd_log.size() - rb, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_wr_addr_i", wr_addr_log[wb+i], 32'h3000 + 32'(i * 32));
      chk("t2_wr_data_i", wr_data_log[wb+i], fillpat);
      chk("t2_strb_i", wr_strb_log[wb+i], 32'hFFFF_FFFF);
    end
    chk("t2_done_vec", done_vec[db], 2'b10);

    // Back-pressure: ch1 copy 16 beats, latency 3, writes stalled 20 cycles
    lat = 3; wr_gnt_i = 1'b0;
    rb = rd_log.size(); wb = wr_addr_log.size(); db = done_cyc.size();
    start_job(1, 32'h8000, 32'h9000, 24'd16, 1'b0, 32'h0);
    repeat (20) @(negedge clk);
    chk("t3_credit_reads", rd_log.size() - rb, 4);
    chk("t3_no_writes", wr_addr_log.size() - wb, 0);
    chk("t3_wr_req", wr_req_o, 1'b1);
    chk("t3_rd_req_blocked", rd_req_o, 1'b0);
    wr_gnt_i = 1'b1;
    wait_done(db + 1, 300, "t3_timeout");
    chk("t3_nrd", rd_log.size() - rb, 16);
    chk("t3_nwr", wr_addr_log.size() - wb, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_wr_addr_i", wr_addr_log[wb+i], 32'h9000 + 32'(i * 32));
      chk("t3_wr_data_i", wr_data_log[wb+i], mkdata(32'h8000 + 32'(i * 32)));
    end

    // Both channels valid, len-1 fills: accepts must alternate 0,1,0,1
    lat = 1;
    ab = acc_ch.size(); db = done_cyc.size(); wb = wr_addr_log.size();
    desc_fill = 2'b11; desc_len[0] = 24'd1; desc_len[1] = 24'd1;
    desc_dst[0] = 32'hA000; desc_dst[1] = 32'hB000;
    desc_pattern[0] = 32'h1111_1111; desc_pattern[1] = 32'h2222_2222;
    desc_valid = 2'b11;
    #1;
    chk("t4_first_ready", desc_ready, 2'b01);
    for (int n = 0; n < 40 && acc_ch.size() < ab + 4; n++) @(negedge clk);
    desc_valid = 2'b00;
    wait_done(db + 4, 30, "t4_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("t4_acc_ch", acc_ch[ab+i], i % 2);
      chk("t4_done_lat", done_cyc[db+i] - acc_cyc[ab+i], 2);
      chk("t4_done_vec", done_vec[db+i], 2'b01 << (i % 2));
    end
    chk("t4_wr0_data", wr_data_log[wb], {8{32'h1111_1111}});
    chk("t4_wr1_addr", wr_addr_log[wb+1], 32'hB000);
    chk("t4_wr1_data", wr_data_log[wb+1], {8{32'h2222_2222}});

    // Zero-length job on ch0
    rb = rd_log.size(); wb = wr_addr_log.size();
    start_job(0, 32'h4000, 32'h4800, 24'd0, 1'b0, 32'h0);
    chk("t5_done", done_o, 2'b01);
    chk("t5_err", err_o, 2'b01);
    chk("t5_rd_req", rd_req_o, 1'b0);
    chk("t5_wr_req", wr_req_o, 1'b0);
    @(negedge clk);
    chk("t5_done_clr", done_o, 2'b00);
    chk("t5_busy_clr", busy_o, 1'b0);
    chk("t5_no_rd", rd_log.size() - rb, 0);
    chk("t5_no_wr", wr_addr_log.size() - wb, 0);

    // Reset with two reads in flight; their late responses must be dropped
    lat = 10; rd_gnt_i = 1'b0;
    rb = rd_log.size(); wb = wr_addr_log.size(); rvb = rv_cnt;
    start_job(0, 32'h7000, 32'h7800, 24'd8, 1'b0, 32'h0);
    rd_gnt_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t6_busy_rst", busy_o, 1'b0);
    chk("t6_rd_req_rst", rd_req_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_inflight_reads", rd_log.size() - rb, 2);
    repeat (15) @(negedge clk);
    chk("t6_stale_delivered", rv_cnt - rvb, 2);
    chk("t6_no_writes", wr_addr_log.size() - wb, 0);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_wr_req", wr_req_o, 1'b0);

    lat = 1; rd_gnt_i = 1'b1;
    rb = rd_log.size(); wb = wr_addr_log.size(); db = done_cyc.size();
    start_job(0, 32'h5000, 32'h6000, 24'd2, 1'b0, 32'h0);
    wait_done(db + 1, 40, "t6_timeout");
    chk("t6_nwr", wr_addr_log.size() - wb, 2);
    for (int i = 0; i < 2; i++) begin
      chk("t6_wr_addr_i", wr_addr_log[wb+i], 32'h6000 + 32'(i * 32));
      chk("t6_wr_data_i", wr_data_log[wb+i], mkdata(32'h5000 + 32'(i * 32)));
    end
    chk("t6_done_vec", done_vec[db], 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_island_copy_engine.md
# memory_island_copy_engine

Parametrised multi-channel block-copy/fill engine for the memory island wide ports, successor to the single-channel register-programmed DMA. Up to NumChannels descriptor sources each present a beat-aligned 1D job on a valid/ready handshake. The engine arbitrates them round-robin and executes one job at a time in one of two modes: COPY (read port into buffer into write port) or FILL (pattern to write port). Reads are credit-limited, with MaxOutstanding reads in flight; buffer occupancy counts against the same credit.

## Interface
- AddrWidth, 32, byte address width
- DataWidth, 256, wide port data width; power of two, at least 32
- NumChannels, 2, number of descriptor channels; at least 1
- MaxOutstanding, 4, read credit = buffer depth; at least 2
- LenWidth, 24, beat-count width
- Derived, do not override: StrbWidth = DataWidth/8; BeatOff = log2(StrbWidth)
- clk_i  in  1  clock; everything sampled on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- desc_valid_i  in  NumChannels  per-channel job valid
- desc_ready_o  out  NumChannels  per-channel job accept
- desc_src_i  in  NumChannels x AddrWidth  source byte address
- desc_dst_i  in  NumChannels x AddrWidth  destination byte address
- desc_len_i  in  NumChannels x LenWidth  length in beats
- desc_fill_i  in  NumChannels  1 = FILL, 0 = COPY
- desc_pattern_i  in  NumChannels x 32  fill word, replicated across DataWidth
- done_o  out  NumChannels  one-cycle completion pulse
- err_o  out  NumChannels  one-cycle pulse, coincident with done_o, for a rejected job
- busy_o  out  1  engine not IDLE
- rd_req_o/rd_gnt_i  out/in  1/1  read request/grant
- rd_addr_o  out  AddrWidth  read address
- rd_rvalid_i/rd_rdata_i  in  1/DataWidth  in-order read response, arbitrary latency, no back-pressure
- wr_req_o/wr_gnt_i  out/in  1/1  write request/grant
- wr_addr_o/wr_wdata_o/wr_strb_o  out  AddrWidth/DataWidth/StrbWidth  write address, data, strobe; strobe is always all ones

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: desc_ready_o is driven combinationally, one-hot, to the round-robin winner among valid channels. The pointer starts at channel 0 after reset and moves to winner+1 (mod NumChannels) on each accept.
- Accept (valid & ready): latch the job; force the low BeatOff bits of src and dst to 0.
  - len != 0: go to RUN.
  - len == 0: go to DONE and flag an error.
- RUN, COPY mode:
  - Issue a read while reads_left > 0 and inflight + fifo_count < MaxOutstanding.
  - On rd_gnt_i: src += StrbWidth, reads_left--, inflight++.
  - On rd_rvalid_i: push to the FIFO, inflight--.
  - wr_req_o = FIFO not empty; wr_wdata_o = FIFO head.
  - On wr_gnt_i: pop, dst += StrbWidth, writes_left--.
- RUN, FILL mode:
  - rd_req_o stays 0.
  - wr_req_o = writes_left > 0; wr_wdata_o = pattern replicated.
- Exit RUN when writes_left reaches 0 on a granted write.
- DONE: lasts one cycle. Pulse done_o[latched channel], and err_o if flagged. Then return to IDLE.
- Address arithmetic wraps modulo 2^AddrWidth. Counters are LenWidth bits; inflight and fifo_count are clog2(MaxOutstanding+1) bits.
- Simultaneous push and pop keeps fifo_count unchanged. Grant and rvalid in the same cycle keeps inflight unchanged.
- Reset during a job clears everything. rd_rvalid_i arriving after reset for pre-reset reads is ignored: the push is gated by inflight > 0.

## Timing
- Reset values: rd_req_o, wr_req_o, busy_o, done_o, err_o and desc_ready_o are all 0. Addresses, wdata and strb are 0 (strb all ones once RUN). FIFO is empty; RR pointer is 0.
- Accept in cycle N: busy_o = 1 from N+1; first rd_req_o (COPY) or wr_req_o (FILL) at N+1.
- rd_rvalid_i in cycle M: wr_req_o may assert at M+1 (registered FIFO, no fall-through).
- Request stability: once asserted, rd_req_o/wr_req_o and their address and data hold until granted.
- Last write granted in cycle K: done_o at K+1, busy_o = 0 at K+2, next job can be accepted at K+2.
- Zero-length job accepted at N: done_o and err_o pulse at N+1.
- Full-rate steady state: 1 beat/cycle when grants are immediate, read latency L, and MaxOutstanding >= L+1.

## Test plan
- COPY ch0, src 0x1000, dst 0x2000, len 4, gnt always 1, latency 1 -> read addrs 0x1000/1020/1040/1060 then write addrs 0x2000..0x2060 with matching data; done_o[0] 1 cycle after the 4th write grant.
- FILL ch1, dst 0x3010 (misaligned), len 3, pattern 0xA5A5_0001 -> writes to 0x3000/3020/3040 with data 8x 0xA5A50001, strb all ones, no rd_req_o.
- Back-pressure: wr_gnt_i = 0 for 20 cycles, latency 3 -> exactly 4 reads issued before the first write; no FIFO overflow; all 16 beats land correctly.
- Both channels valid continuously with len 1 -> accepts alternate 0,1,0,1; each done within 4 cycles of accept.
- len 0 on ch0 -> done_o[0] & err_o[0] at N+1; no memory traffic.
- Assert rst_i mid-job with 2 reads in flight, then deliver 2 stale rvalids -> no writes, busy_o = 0, FIFO empty; a following len-2 job completes correctly.
